// File: rtl/conv1d_window_ctrl_if.sv
// rtl/conv1d_window_ctrl_if.sv - sample, weight, MAC and result signals of the conv1d window controller
interface conv1d_window_ctrl_if;
  logic               load_w;
  logic signed [7:0]  w_in;
  logic signed [15:0] bias_in;
  logic               restart;
  logic               x_valid;
  logic signed [7:0]  x_in;
  logic               x_ready;
  logic               mac_clear;
  logic               mac_valid;
  logic signed [7:0]  mac_w;
  logic signed [7:0]  mac_x;
  logic signed [15:0] mac_psum_in;
  logic signed [15:0] mac_psum_out;
  logic               y_valid;
  logic signed [15:0] y_out;

  modport master (
    output load_w, w_in, bias_in, restart, x_valid, x_in, mac_psum_out,
    input  x_ready, mac_clear, mac_valid, mac_w, mac_x, mac_psum_in, y_valid, y_out
  );

  modport slave (
    input  load_w, w_in, bias_in, restart, x_valid, x_in, mac_psum_out,
    output x_ready, mac_clear, mac_valid, mac_w, mac_x, mac_psum_in, y_valid, y_out
  );
endinterface

// File: rtl/conv1d_window_ctrl.sv
// rtl/conv1d_window_ctrl.sv - K-tap sliding-window sequencer that streams taps into an external MAC
module conv1d_window_ctrl #(
  parameter int K = 3
) (
  input logic                 clk,
  input logic                 rst_n,
  conv1d_window_ctrl_if.slave bus
);
  localparam int PW = $clog2(K);
  localparam int CW = $clog2(K + 1);

  typedef enum logic [1:0] {IDLE, MAC, VALID, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic signed [7:0] w   [K];
  logic signed [7:0] win [K];
  logic [PW-1:0]     w_ptr;
  logic [PW-1:0]     tap;
  logic [CW-1:0]     fill_cnt;
  logic              idle_ready;
  logic              accept;

  // Weight loads and restarts take priority over samples in IDLE.
  assign idle_ready = (state == IDLE) && !bus.load_w && !bus.restart;
  assign accept     = idle_ready && bus.x_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && (fill_cnt >= CW'(K - 1))) state_nxt = MAC;
      MAC:     if (tap == PW'(K - 1)) state_nxt = VALID;
      VALID:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.x_ready     = rst_n && idle_ready;
    bus.mac_clear   = 1'b0;
    bus.mac_valid   = 1'b0;
    bus.mac_w       = '0;
    bus.mac_x       = '0;
    bus.mac_psum_in = '0;
    case (state)
      MAC: begin
        bus.mac_w = w[tap];
        bus.mac_x = win[tap];
      end
      VALID: begin
        bus.mac_valid   = 1'b1;
        bus.mac_psum_in = bus.bias_in;
      end
      default: bus.mac_clear = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < K; j++) begin
        w[j]   <= '0;
        win[j] <= '0;
      end
      w_ptr       <= '0;
      fill_cnt    <= '0;
      tap         <= '0;
      bus.y_valid <= 1'b0;
      bus.y_out   <= '0;
    end else begin
      if ((state == IDLE) && bus.load_w) begin
        w[w_ptr] <= bus.w_in;
        w_ptr    <= (w_ptr == PW'(K - 1)) ? '0 : w_ptr + PW'(1);
      end else if ((state == IDLE) && bus.restart) begin
        for (int j = 0; j < K; j++) win[j] <= '0;
        fill_cnt <= '0;
      end else if (accept) begin
        for (int j = 0; j < K - 1; j++) win[j] <= win[j + 1];
        win[K-1] <= bus.x_in;
        if (fill_cnt != CW'(K)) fill_cnt <= fill_cnt + CW'(1);
      end
      tap         <= (state == MAC) ? tap + PW'(1) : '0;
      bus.y_valid <= (state == DONE);
      // The MAC output is registered, so it already holds bias + taps while in DONE.
      if (state == DONE) bus.y_out <= bus.mac_psum_out;
    end
  end
endmodule

// File: tb/tb_conv1d_window_ctrl.sv
// tb/tb_conv1d_window_ctrl.sv - randomized and directed bench for conv1d_window_ctrl with a MAC stand-in
module tb_conv1d_window_ctrl;
  localparam int K = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv1d_window_ctrl_if bus();
  conv1d_window_ctrl #(.K(K)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Stand-in MAC: registered accumulator, clear wins, bias added on mac_valid.
  logic signed [15:0] acc = '0;
  always @(posedge clk) begin
    if (bus.mac_clear) acc <= '0;
    else acc <= acc + 16'(bus.mac_w) * 16'(bus.mac_x) + (bus.mac_valid ? bus.mac_psum_in : 16'sd0);
  end
  assign bus.mac_psum_out = acc;

  int n_total = 0;
  int n_pass = 0;

  function automatic void chk(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endfunction

  // Reference: one window in flight, occupying K+3 edges from its accepting edge.
  int                 m_w   [K];
  int                 m_win [K];
  int                 m_ptr, m_fill, m_cyc, m_acc_cyc, m_sum;
  bit                 m_busy, m_yv;
  logic signed [15:0] m_bias, m_y;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int j = 0; j < K; j++) begin
        m_w[j] = 0;
        m_win[j] = 0;
      end
      m_ptr = 0; m_fill = 0; m_cyc = 0; m_acc_cyc = 0; m_sum = 0;
      m_busy = 0; m_yv = 0; m_y = '0; m_bias = '0;
    end else begin
      m_cyc++;
      m_yv = 0;
      if (m_busy) begin
        if (m_cyc == m_acc_cyc + K + 1) m_bias = bus.bias_in;
        if (m_cyc == m_acc_cyc + K + 2) begin
          m_y = 16'(m_sum + int'(m_bias));
          m_yv = 1;
          m_busy = 0;
        end
      end else if (bus.load_w) begin
        m_w[m_ptr] = bus.w_in;
        m_ptr = (m_ptr + 1) % K;
      end else if (bus.restart) begin
        for (int j = 0; j < K; j++) m_win[j] = 0;
        m_fill = 0;
      end else if (bus.x_valid) begin
        for (int j = 0; j < K - 1; j++) m_win[j] = m_win[j + 1];
        m_win[K-1] = bus.x_in;
        if (m_fill >= K - 1) begin
          m_busy = 1;
          m_acc_cyc = m_cyc;
          m_sum = 0;
          for (int j = 0; j < K; j++) m_sum += m_w[j] * m_win[j];
        end
        if (m_fill < K) m_fill++;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      int ph;
      int idx;
      bit in_mac;
      ph = m_cyc - m_acc_cyc;
      in_mac = m_busy && (ph >= 0) && (ph < K);
      idx = in_mac ? ph : 0;
      chk("y_valid", int'(bus.y_valid), int'(m_yv));
      chk("y_out", int'(bus.y_out), int'(m_y));
      chk("x_ready", int'(bus.x_ready), int'(!m_busy && !bus.load_w && !bus.restart));
      chk("mac_clear", int'(bus.mac_clear), int'(!m_busy || (ph == K + 1)));
      chk("mac_valid", int'(bus.mac_valid), int'(m_busy && (ph == K)));
      chk("mac_w", int'(bus.mac_w), in_mac ? m_w[idx] : 0);
      chk("mac_x", int'(bus.mac_x), in_mac ? m_win[idx] : 0);
      chk("mac_psum_in", int'(bus.mac_psum_in), (m_busy && (ph == K)) ? int'(bus.bias_in) : 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load(int v);
    bus.load_w = 1'b1;
    bus.w_in = 8'(v);
    tick();
    bus.load_w = 1'b0;
  endtask

  task automatic do_restart();
    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
  endtask

  task automatic send(int v);
    bit ok;
    ok = 0;
    bus.x_valid = 1'b1;
    bus.x_in = 8'(v);
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      ok = bus.x_ready;
      tick();
    end
    bus.x_valid = 1'b0;
    chk("send_accepted", int'(ok), 1);
  endtask

  task automatic expect_y(string name, int exp, int lat);
    bit seen;
    int n;
    seen = 0;
    n = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      seen = bus.y_valid;
    end
    chk({name, "_seen"}, int'(seen), 1);
    chk({name, "_value"}, int'(bus.y_out), exp);
    chk({name, "_latency"}, n, lat);
    tick();
  endtask

  task automatic expect_none(string name, int cycles);
    int cnt;
    cnt = 0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      if (bus.y_valid) cnt++;
    end
    chk(name, cnt, 0);
    tick();
  endtask

  task automatic check_reset_outputs(string name);
    chk({name, "_x_ready"}, int'(bus.x_ready), 0);
    chk({name, "_mac_clear"}, int'(bus.mac_clear), 1);
    chk({name, "_mac_valid"}, int'(bus.mac_valid), 0);
    chk({name, "_mac_w"}, int'(bus.mac_w), 0);
    chk({name, "_mac_x"}, int'(bus.mac_x), 0);
    chk({name, "_mac_psum_in"}, int'(bus.mac_psum_in), 0);
    chk({name, "_y_valid"}, int'(bus.y_valid), 0);
    chk({name, "_y_out"}, int'(bus.y_out), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.load_w = 1'b0; bus.w_in = '0; bus.bias_in = '0; bus.restart = 1'b0;
    bus.x_valid = 1'b0; bus.x_in = '0;
    #3;
    check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    tick();

    load(1); load(2); load(3);
    send(1); send(2);
    send(3);
    expect_y("win123", 14, K + 3);
    send(4);
    expect_y("win234", 20, K + 3);
    bus.bias_in = 16'sd5;
    send(5);
    expect_y("win345_bias", 31, K + 3);
    bus.bias_in = 16'sd0;

    do_restart();
    load(-128); load(-128); load(-128);
    send(-128); send(-128); send(-128);
    expect_y("wrap", -16384, K + 3);

    do_restart();
    load(1); load(1); load(1);
    send(1); send(1); send(1);
    expect_y("ones", 3, K + 3);
    do_restart();
    send(7); send(7);
    expect_none("restart_refill", K + 4);
    send(7);
    expect_y("sevens", 21, K + 3);

    do_restart();
    load(9); load(1); load(1);
    bus.load_w = 1'b1; bus.w_in = 8'sd2; bus.x_valid = 1'b1; bus.x_in = 8'sd1;
    @(negedge clk);
    chk("load_blocks_sample", int'(bus.x_ready), 0);
    tick();
    bus.load_w = 1'b0;
    send(1); send(1); send(1);
    expect_y("ptr_wrap", 4, K + 3);

    send(1); send(1); send(1);
    tick();
    #4;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_window");
    @(posedge clk);
    #2;
    tick();
    rst_n = 1'b1;
    expect_none("aborted_window", K + 4);
    load(1); load(2); load(3);
    send(1); send(2);
    expect_none("post_reset_fill", K + 4);
    send(3);
    expect_y("post_reset", 14, K + 3);

    for (int i = 0; i < 3000; i++) begin
      bus.load_w  = ($urandom_range(7) == 0);
      bus.restart = ($urandom_range(15) == 0);
      bus.x_valid = ($urandom_range(1) == 1);
      bus.w_in    = 8'($urandom);
      bus.x_in    = 8'($urandom);
      if ($urandom_range(3) == 0) bus.bias_in = 16'($urandom);
      if (i == 1500) begin
        #4;
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
      end
      tick();
    end
    bus.load_w = 1'b0; bus.restart = 1'b0; bus.x_valid = 1'b0;
    repeat (K + 4) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
